// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
//   requester_t : identifies the CPU or the debug/loader port
//   rd_pend_t   : outstanding read return (valid + owning requester)
package dmem_arb_pkg;

    localparam int unsigned DMEM_DATA_W = 16;
    localparam int unsigned DMEM_ADDR_W = 8;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } requester_t;

    typedef struct packed {
        logic       valid;
        requester_t owner;
    } rd_pend_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory array.
//   cpu_* : CPU load/store request, grant and read return
//   dbg_* : debug/loader request (with burst lock), grant and read return
//   mem_* : single-port memory command and read data
// Modports: slave = arbiter side, master = environment (requesters + memory).
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// and a debug/loader port, with a bounded debug burst lock and read-data
// routing back to the issuing requester.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dmem_arbiter_if.slave (requester handshakes + memory command)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = DMEM_DATA_W,
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned       LOCK_W   = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    requester_t        r_last;
    requester_t        w_last_nxt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_cnt_nxt;
    rd_pend_t          r_rd_pend;
    rd_pend_t          w_rd_pend_nxt;

    logic              w_tie_dbg;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= REQ_DBG;
            r_lock_cnt <= '0;
            r_rd_pend  <= '{valid: 1'b0, owner: REQ_CPU};
        end else begin
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
        end
    end

    // Grant decision, memory command mux and next-state
    always_comb begin
        w_tie_dbg      = 1'b0;
        w_cpu_gnt      = 1'b0;
        w_dbg_gnt      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = '0;
        w_mem_wdata    = '0;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        w_rd_pend_nxt  = '{valid: 1'b0, owner: REQ_CPU};

        // Tie goes to debug if CPU went last, or debug holds an unexpired lock
        w_tie_dbg = (r_last == REQ_CPU) |
                    (bus.dbg_lock & (r_last == REQ_DBG) & (r_lock_cnt != LOCK_MAX));

        w_cpu_gnt = ~rst & bus.cpu_req & ~(bus.dbg_req & w_tie_dbg);
        w_dbg_gnt = ~rst & bus.dbg_req & ~(bus.cpu_req & ~w_tie_dbg);

        if (w_cpu_gnt) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_last_nxt  = REQ_CPU;
        end else if (w_dbg_gnt) begin
            w_mem_we    = bus.dbg_we;
            w_mem_addr  = bus.dbg_addr;
            w_mem_wdata = bus.dbg_wdata;
            w_last_nxt  = REQ_DBG;
        end

        // Lock counter saturates at MAX_LOCK so a sole locked debug stream cannot wrap
        if (w_cpu_gnt || !bus.dbg_lock) begin
            w_lock_cnt_nxt = '0;
        end else if (w_dbg_gnt && (r_lock_cnt != LOCK_MAX)) begin
            w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
        end

        w_rd_pend_nxt.valid = (w_cpu_gnt | w_dbg_gnt) & ~w_mem_we;
        w_rd_pend_nxt.owner = w_dbg_gnt ? REQ_DBG : REQ_CPU;
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.mem_en     = w_cpu_gnt | w_dbg_gnt;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;

    // Read data is broadcast; only rvalid tells a requester it is theirs
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.cpu_rvalid = r_rd_pend.valid & (r_rd_pend.owner == REQ_CPU);
    assign bus.dbg_rvalid = r_rd_pend.valid & (r_rd_pend.owner == REQ_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned ML = 3;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [DW-1:0] mem [0:255];
    logic [5:0]    lock_pat;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory, read data one cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic dr, input logic dw,
                         input logic dl, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dbg_req   = dr;
        bus.dbg_we    = dw;
        bus.dbg_lock  = dl;
        bus.dbg_addr  = da;
        bus.dbg_wdata = dd;
    endtask

    // One bus cycle: inputs already driven just after a falling edge
    task automatic cyc(input string tag, input logic ecg, input logic edg,
                       input logic ecv, input logic edv, input logic [DW-1:0] erd);
        #1;
        chk({tag, ".cpu_gnt"}, 32'(bus.cpu_gnt), 32'(ecg));
        chk({tag, ".dbg_gnt"}, 32'(bus.dbg_gnt), 32'(edg));
        @(posedge clk);
        #1;
        chk({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(ecv));
        chk({tag, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(edv));
        if (ecv || edv) begin
            chk({tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'(erd));
            chk({tag, ".dbg_rdata"}, 32'(bus.dbg_rdata), 32'(erd));
        end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;

        // Reset with both requesting
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
        chk("rst.dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        chk("rst.mem_en",     32'(bus.mem_en),     32'd0);
        chk("rst.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst.dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("rel", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);

        // CPU write then read
        drive(1'b1, 1'b1, 8'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        #1;
        chk("cwr.mem_we",    32'(bus.mem_we),    32'd1);
        chk("cwr.mem_addr",  32'(bus.mem_addr),  32'd5);
        chk("cwr.mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        cyc("cwr", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 8'd5, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cyc("crd", 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);

        // Debug write (makes debug the last grantee)
        drive(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b1, 1'b0, 8'd6, 16'hBEEF);
        #1;
        chk("dwr.mem_addr",  32'(bus.mem_addr),  32'd6);
        chk("dwr.mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        cyc("dwr", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

        // Round robin, both reading continuously
        drive(1'b1, 1'b0, 8'd5, 16'h0, 1'b1, 1'b0, 1'b0, 8'd6, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc($sformatf("rr%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
            else            cyc($sformatf("rr%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        end

        // Debug lock with MAX_LOCK=3: D,D,D,C,D,D
        lock_pat = 6'b110111;
        drive(1'b1, 1'b0, 8'd5, 16'h0, 1'b1, 1'b0, 1'b1, 8'd6, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (lock_pat[i]) cyc($sformatf("lk%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
            else             cyc($sformatf("lk%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
        end
        drive(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Loader preload of addresses 1..10, then CPU reads them back
        for (int a = 1; a <= 10; a++) begin
            drive(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b1, 1'b0, 8'(a), 16'(a));
            cyc($sformatf("pre%0d", a), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        end
        for (int a = 1; a <= 10; a++) begin
            drive(1'b1, 1'b0, 8'(a), 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
            cyc($sformatf("run%0d", a), 1'b1, 1'b0, 1'b1, 1'b0, 16'(a));
        end

        // Same address: debug write wins the tie, CPU read then sees new data
        drive(1'b1, 1'b0, 8'd20, 16'h0, 1'b1, 1'b1, 1'b0, 8'd20, 16'h55AA);
        cyc("rw0", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 8'd20, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cyc("rw1", 1'b1, 1'b0, 1'b1, 1'b0, 16'h55AA);

        // Reset pulse while a debug read is granted
        drive(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd20, 16'h0);
        #1;
        chk("rdr.dbg_gnt_pre", 32'(bus.dbg_gnt), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rdr.dbg_gnt_rst", 32'(bus.dbg_gnt),    32'd0);
        chk("rdr.mem_en_rst",  32'(bus.mem_en),     32'd0);
        chk("rdr.dbg_rvalid0", 32'(bus.dbg_rvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("rdr.dbg_rvalid1", 32'(bus.dbg_rvalid), 32'd0);
        chk("rdr.cpu_rvalid1", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'd20, 16'h0, 1'b1, 1'b0, 1'b0, 8'd20, 16'h0);
        chk("rdr.dbg_rvalid2", 32'(bus.dbg_rvalid), 32'd0);
        cyc("post0", 1'b1, 1'b0, 1'b1, 1'b0, 16'h55AA);
        cyc("post1", 1'b0, 1'b1, 1'b0, 1'b1, 16'h55AA);

        drive(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
